mm_job_ctrl: RTL and testbench

- Job sequencer in front of MM_ultra; accepts one matrix-multiply descriptor at a time and drives MM_ultra's static config inputs (shift, F_length, F_width_block_num, W_width_block_num) for the whole job.
- Gates the upstream F and W streams into MM_ultra and generates their last flags from beat counters.
- Monitors the output handshake, checks the output beat count, then reports completion and any count mismatch.

---
 rtl/mm_ctrl_pkg.sv | 19 +
 rtl/mm_stream_gate.sv | 36 +++
 rtl/mm_job_ctrl.sv | 157 +++++++++++++++
 tb/tb_mm_job_ctrl.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/mm_ctrl_pkg.sv
// Shared types and default widths for the MM_ultra job sequencer (mm_job_ctrl).
package mm_ctrl_pkg;
  localparam int A_SIZE_D      = 16;
  localparam int SHIFT_W_D     = 10;
  localparam int F_LENGTH_W_D  = 10;
  localparam int F_WBN_W_D     = 5;
  localparam int W_WBN_W_D     = 5;
  localparam int DATA_W_D      = A_SIZE_D * 8;
  localparam int CNT_W_D       = 24;

  typedef enum logic [2:0] {IDLE, SETUP, STREAM, DRAIN, DONE} state_e;

  typedef struct packed {
    logic [SHIFT_W_D-1:0]    shift;
    logic [F_LENGTH_W_D-1:0] f_length;
    logic [F_WBN_W_D-1:0]    f_wbn;
    logic [W_WBN_W_D-1:0]    w_wbn;
  } job_desc_t;
endpackage

// File: rtl/mm_stream_gate.sv
// Counter-based valid/ready gate: passes exactly `target` beats while enabled, flags the last one.
module mm_stream_gate #(
  parameter int DATA_W    = 128,
  parameter int CNT_WIDTH = 24
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 en,
  input  logic [CNT_WIDTH-1:0] target,
  input  logic                 src_valid,
  output logic                 src_ready,
  input  logic [DATA_W-1:0]    src_data,
  output logic                 dst_valid,
  input  logic                 dst_ready,
  output logic [DATA_W-1:0]    dst_data,
  output logic                 dst_last,
  output logic                 complete
);
  logic [CNT_WIDTH-1:0] cnt;
  logic                 open;

  assign open      = en && (cnt < target);
  assign dst_valid = open & src_valid;
  assign src_ready = open & dst_ready;
  assign dst_data  = src_data;
  assign dst_last  = open && (cnt == target - 1'b1);
  // target is never zero while enabled; descriptors with zero fields are rejected upstream
  assign complete  = (cnt == target);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      cnt <= '0;
    else if (clr)                    cnt <= '0;
    else if (dst_valid && dst_ready) cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/mm_job_ctrl.sv
// Job sequencer in front of MM_ultra: latches one descriptor, gates F/W streams, checks output count.
// Optional perf counters (perf_cycles, perf_stall) are built when MM_JOB_PERF_EN is defined.
module mm_job_ctrl
  import mm_ctrl_pkg::*;
#(
  parameter int A_SIZE         = A_SIZE_D,
  parameter int SHIFT_WIDTH    = SHIFT_W_D,
  parameter int F_LENGTH_WIDTH = F_LENGTH_W_D,
  parameter int F_WBN_WIDTH    = F_WBN_W_D,
  parameter int W_WBN_WIDTH    = W_WBN_W_D,
  parameter int DATA_W         = DATA_W_D,
  parameter int CNT_WIDTH      = CNT_W_D
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      job_valid,
  output logic                      job_ready,
  input  logic [SHIFT_WIDTH-1:0]    job_shift,
  input  logic [F_LENGTH_WIDTH-1:0] job_f_length,
  input  logic [F_WBN_WIDTH-1:0]    job_f_wbn,
  input  logic [W_WBN_WIDTH-1:0]    job_w_wbn,
  output logic [SHIFT_WIDTH-1:0]    cfg_shift,
  output logic [F_LENGTH_WIDTH-1:0] cfg_f_length,
  output logic [F_WBN_WIDTH-1:0]    cfg_f_wbn,
  output logic [W_WBN_WIDTH-1:0]    cfg_w_wbn,
  input  logic                      src_f_valid,
  output logic                      src_f_ready,
  input  logic [DATA_W-1:0]         src_f_data,
  output logic                      mm_f_valid,
  input  logic                      mm_f_ready,
  output logic [DATA_W-1:0]         mm_f_data,
  output logic                      mm_f_last,
  input  logic                      src_w_valid,
  output logic                      src_w_ready,
  input  logic [DATA_W-1:0]         src_w_data,
  output logic                      mm_w_valid,
  input  logic                      mm_w_ready,
  output logic [DATA_W-1:0]         mm_w_data,
  output logic                      mm_w_last,
  input  logic                      mon_out_valid,
  input  logic                      mon_out_ready,
  input  logic                      mon_out_last,
  output logic                      busy,
  output logic                      done,
  output logic                      err_cfg,
  output logic                      err_cnt
`ifdef MM_JOB_PERF_EN
  ,
  output logic [31:0]               perf_cycles,
  output logic [31:0]               perf_stall
`endif
);
  state_e               state_q, state_d;
  job_desc_t            cfg_q;
  logic [CNT_WIDTH-1:0] nf_q, nw_q, no_q, o_cnt;
  logic                 last_seen;
  logic                 accept, cfg_bad, load, out_hs, f_cmp, w_cmp, stream_en;

  assign accept    = job_valid & job_ready;
  assign cfg_bad   = (job_f_length == '0) | (job_f_wbn == '0) | (job_w_wbn == '0);
  assign load      = accept & ~cfg_bad;
  assign stream_en = (state_q == STREAM);
  // Output beats are counted from STREAM on: MM_ultra may emit before W is fully delivered
  assign out_hs    = mon_out_valid & mon_out_ready & ((state_q == STREAM) | (state_q == DRAIN));

  assign cfg_shift    = cfg_q.shift;
  assign cfg_f_length = cfg_q.f_length;
  assign cfg_f_wbn    = cfg_q.f_wbn;
  assign cfg_w_wbn    = cfg_q.w_wbn;

  always_comb begin
    state_d   = state_q;
    job_ready = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    case (state_q)
      IDLE: begin
        job_ready = 1'b1;
        busy      = 1'b0;
        if (load) state_d = SETUP;
      end
      SETUP:  state_d = STREAM;
      STREAM: if (f_cmp && w_cmp) state_d = DRAIN;
      DRAIN:  if (last_seen || (out_hs && mon_out_last)) state_d = DONE;
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cfg_q     <= '0;
      nf_q      <= '0;
      nw_q      <= '0;
      no_q      <= '0;
      o_cnt     <= '0;
      last_seen <= 1'b0;
      err_cfg   <= 1'b0;
      err_cnt   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_cfg <= accept & cfg_bad;
      if (load) begin
        cfg_q     <= '{job_shift, job_f_length, job_f_wbn, job_w_wbn};
        nf_q      <= CNT_WIDTH'(job_f_length) * CNT_WIDTH'(job_f_wbn);
        nw_q      <= CNT_WIDTH'(job_f_wbn) * CNT_WIDTH'(A_SIZE) * CNT_WIDTH'(job_w_wbn);
        no_q      <= CNT_WIDTH'(job_f_length) * CNT_WIDTH'(job_w_wbn);
        o_cnt     <= '0;
        last_seen <= 1'b0;
        err_cnt   <= 1'b0;
      end else if (out_hs) begin
        o_cnt <= o_cnt + 1'b1;
        if (mon_out_last) begin
          last_seen <= 1'b1;
          if (o_cnt != no_q - 1'b1) err_cnt <= 1'b1;
        end else if (o_cnt == no_q - 1'b1) begin
          err_cnt <= 1'b1;
        end
      end
    end
  end

  mm_stream_gate #(.DATA_W(DATA_W), .CNT_WIDTH(CNT_WIDTH)) u_gate_f (
    .clk(clk), .rst_n(rst_n), .clr(load), .en(stream_en), .target(nf_q),
    .src_valid(src_f_valid), .src_ready(src_f_ready), .src_data(src_f_data),
    .dst_valid(mm_f_valid), .dst_ready(mm_f_ready), .dst_data(mm_f_data),
    .dst_last(mm_f_last), .complete(f_cmp)
  );

  mm_stream_gate #(.DATA_W(DATA_W), .CNT_WIDTH(CNT_WIDTH)) u_gate_w (
    .clk(clk), .rst_n(rst_n), .clr(load), .en(stream_en), .target(nw_q),
    .src_valid(src_w_valid), .src_ready(src_w_ready), .src_data(src_w_data),
    .dst_valid(mm_w_valid), .dst_ready(mm_w_ready), .dst_data(mm_w_data),
    .dst_last(mm_w_last), .complete(w_cmp)
  );

`ifdef MM_JOB_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_cycles <= '0;
      perf_stall  <= '0;
    end else if (load) begin
      perf_cycles <= 32'd1;
      perf_stall  <= '0;
    end else begin
      if (busy && perf_cycles != '1) perf_cycles <= perf_cycles + 1'b1;
      if (stream_en && ((mm_f_valid & ~mm_f_ready) | (mm_w_valid & ~mm_w_ready)) &&
          perf_stall != '1)
        perf_stall <= perf_stall + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_mm_job_ctrl.sv
// Directed table-driven bench for mm_job_ctrl; perf checks compile in with MM_JOB_PERF_EN.
module tb_mm_job_ctrl;
  localparam int DW = 128;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          job_valid = 1'b0, job_ready;
  logic [9:0]    job_shift = '0, job_f_length = '0;
  logic [4:0]    job_f_wbn = '0, job_w_wbn = '0;
  logic [9:0]    cfg_shift, cfg_f_length;
  logic [4:0]    cfg_f_wbn, cfg_w_wbn;
  logic          src_f_valid = 1'b0, src_f_ready, mm_f_valid, mm_f_ready = 1'b1, mm_f_last;
  logic          src_w_valid = 1'b0, src_w_ready, mm_w_valid, mm_w_ready = 1'b1, mm_w_last;
  logic [DW-1:0] src_f_data = '0, src_w_data = '0, mm_f_data, mm_w_data;
  logic          mon_out_valid = 1'b0, mon_out_ready = 1'b1, mon_out_last = 1'b0;
  logic          busy, done, err_cfg, err_cnt;
`ifdef MM_JOB_PERF_EN
  logic [31:0]   perf_cycles, perf_stall;
`endif

  always #5 clk = ~clk;

  mm_job_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .job_valid(job_valid), .job_ready(job_ready), .job_shift(job_shift),
    .job_f_length(job_f_length), .job_f_wbn(job_f_wbn), .job_w_wbn(job_w_wbn),
    .cfg_shift(cfg_shift), .cfg_f_length(cfg_f_length), .cfg_f_wbn(cfg_f_wbn), .cfg_w_wbn(cfg_w_wbn),
    .src_f_valid(src_f_valid), .src_f_ready(src_f_ready), .src_f_data(src_f_data),
    .mm_f_valid(mm_f_valid), .mm_f_ready(mm_f_ready), .mm_f_data(mm_f_data), .mm_f_last(mm_f_last),
    .src_w_valid(src_w_valid), .src_w_ready(src_w_ready), .src_w_data(src_w_data),
    .mm_w_valid(mm_w_valid), .mm_w_ready(mm_w_ready), .mm_w_data(mm_w_data), .mm_w_last(mm_w_last),
    .mon_out_valid(mon_out_valid), .mon_out_ready(mon_out_ready), .mon_out_last(mon_out_last),
    .busy(busy), .done(done), .err_cfg(err_cfg), .err_cnt(err_cnt)
`ifdef MM_JOB_PERF_EN
    , .perf_cycles(perf_cycles), .perf_stall(perf_stall)
`endif
  );

  typedef struct {
    int shift, fl, fwbn, wwbn;
    bit bp;
    int nf, nw, last_at;
    bit err, rej;
  } vec_t;

  int n_cmp = 0, n_bad = 0, cyc = 0;
  int f_hs = 0, w_hs = 0, f_last_at = -1, w_last_at = -1, data_bad = 0, cfg_bad = 0;
  logic [9:0] e_shift = '0, e_fl = '0;
  logic [4:0] e_fwbn = '0, e_wwbn = '0;

  always @(posedge clk) cyc++;

  // Handshakes are decided by values stable since the last posedge, so observe them at negedge
  always @(negedge clk) begin
    if (mm_f_valid && mm_f_ready) begin
      if (mm_f_last) f_last_at = f_hs;
      f_hs++;
    end
    if (mm_w_valid && mm_w_ready) begin
      if (mm_w_last) w_last_at = w_hs;
      w_hs++;
    end
    if ((mm_f_valid && mm_f_data !== src_f_data) || (mm_w_valid && mm_w_data !== src_w_data))
      data_bad++;
    if (busy && ({cfg_shift, cfg_f_length, cfg_f_wbn, cfg_w_wbn} !== {e_shift, e_fl, e_fwbn, e_wwbn}))
      cfg_bad++;
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic run_job(input vec_t v);
    int fb, wb, cb, db, k, acc_c, done_c;
    fb = f_hs; wb = w_hs; cb = cfg_bad; db = data_bad;
    job_shift = 10'(v.shift); job_f_length = 10'(v.fl);
    job_f_wbn = 5'(v.fwbn);   job_w_wbn = 5'(v.wwbn);
    job_valid = 1'b1;
    chk("job_ready_idle", job_ready, 1);
    acc_c = cyc;
    step;
    job_valid = 1'b0;
    if (v.rej) begin
      chk("err_cfg_pulse", err_cfg, 1);
      chk("busy_after_reject", busy, 0);
      chk("cfg_after_reject", {cfg_shift, cfg_f_length, cfg_f_wbn, cfg_w_wbn},
          {e_shift, e_fl, e_fwbn, e_wwbn});
      step;
      chk("err_cfg_one_cycle", err_cfg, 0);
      return;
    end
    e_shift = 10'(v.shift); e_fl = 10'(v.fl); e_fwbn = 5'(v.fwbn); e_wwbn = 5'(v.wwbn);
    chk("busy_after_accept", busy, 1);
    chk("err_cnt_cleared", err_cnt, 0);
    chk("cfg_loaded", {cfg_shift, cfg_f_length, cfg_f_wbn, cfg_w_wbn},
        {e_shift, e_fl, e_fwbn, e_wwbn});
    src_f_valid = 1'b1; src_w_valid = 1'b1;
    k = 0;
    while ((f_hs - fb < v.nf || w_hs - wb < v.nw) && k < 5000) begin
      mm_f_ready = v.bp ? 1'($urandom_range(0, 1)) : 1'b1;
      mm_w_ready = v.bp ? 1'($urandom_range(0, 1)) : 1'b1;
      src_f_data = {4{$urandom()}};
      src_w_data = {4{$urandom()}};
      step;
      k++;
    end
    chk("stream_in_budget", k < 5000, 1);
    mm_f_ready = 1'b1; mm_w_ready = 1'b1;
    repeat (3) step;
    chk("f_beats", f_hs - fb, v.nf);
    chk("w_beats", w_hs - wb, v.nw);
    chk("f_last_idx", f_last_at - fb, v.nf - 1);
    chk("w_last_idx", w_last_at - wb, v.nw - 1);
    chk("f_gate_closed", {src_f_ready, mm_f_valid}, 0);
    chk("w_gate_closed", {src_w_ready, mm_w_valid}, 0);
    for (int b = 0; b <= v.last_at; b++) begin
      mon_out_valid = 1'b1;
      mon_out_last  = (b == v.last_at);
      step;
    end
    mon_out_valid = 1'b0; mon_out_last = 1'b0;
    k = 0;
    while (!done && k < 20) begin
      step;
      k++;
    end
    chk("done_seen", done, 1);
    done_c = cyc;
    step;
    chk("done_one_cycle", done, 0);
    chk("busy_after_done", busy, 0);
    chk("err_cnt", err_cnt, v.err);
    chk("cfg_held_after_done", {cfg_shift, cfg_f_length, cfg_f_wbn, cfg_w_wbn},
        {e_shift, e_fl, e_fwbn, e_wwbn});
    chk("cfg_stable_in_job", cfg_bad - cb, 0);
    chk("data_passthrough", data_bad - db, 0);
`ifdef MM_JOB_PERF_EN
    if (!v.bp) begin
      chk("perf_stall", perf_stall, 0);
      chk("perf_cycles", perf_cycles, done_c - acc_c + 1);
    end
`endif
    src_f_valid = 1'b0; src_w_valid = 1'b0;
    step;
  endtask

  initial begin
    vec_t tbl[10];
    vec_t v;
    int k;
    //           shift  fl fwbn wwbn bp   nf   nw last err rej
    tbl[0] = '{9,  200, 6, 10, 0, 1200, 960, 1999, 0, 0};
    tbl[1] = '{1,    3, 1,  1, 1,    3,  16,    2, 0, 0};
    tbl[2] = '{0,   10, 1,  1, 0,   10,  16,    4, 1, 0};  // last on beat 5 of 10
    tbl[3] = '{2,    5, 2,  3, 0,   10,  96,   14, 0, 0};
    tbl[4] = '{3,    1, 1,  1, 0,    1,  16,    0, 0, 0};
    tbl[5] = '{7,    4, 1,  2, 0,    4,  32,    8, 1, 0};  // NO=8 reached, last arrives late
    tbl[6] = '{4,    5, 0,  2, 0,    0,   0,    0, 0, 1};
    tbl[7] = '{4,    0, 3,  2, 0,    0,   0,    0, 0, 1};
    tbl[8] = '{4,    5, 3,  0, 0,    0,   0,    0, 0, 1};
    tbl[9] = '{1,    1, 1,  1, 0,    1,  16,    0, 0, 0};

    src_f_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_job_ready", job_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_flags", {done, err_cfg, err_cnt}, 0);
    chk("rst_cfg", {cfg_shift, cfg_f_length, cfg_f_wbn, cfg_w_wbn}, 0);
    chk("rst_gate", {mm_f_valid, src_f_ready}, 0);
    src_f_valid = 1'b0;
    rst_n = 1'b1;
    step;

    for (int i = 0; i < 10; i++) run_job(tbl[i]);

    // Reset in the middle of a streaming job
    job_shift = 10'd9; job_f_length = 10'd200; job_f_wbn = 5'd6; job_w_wbn = 5'd10;
    job_valid = 1'b1;
    step;
    job_valid = 1'b0;
    e_shift = 10'd9; e_fl = 10'd200; e_fwbn = 5'd6; e_wwbn = 5'd10;
    src_f_valid = 1'b1; src_w_valid = 1'b1;
    repeat (20) step;
    chk("stream_before_reset", mm_f_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("reset_busy", busy, 0);
    chk("reset_gates", {mm_f_valid, mm_w_valid}, 0);
    chk("reset_job_ready", job_ready, 1);
    chk("reset_cfg", {cfg_shift, cfg_f_length, cfg_f_wbn, cfg_w_wbn}, 0);
    e_shift = '0; e_fl = '0; e_fwbn = '0; e_wwbn = '0;
    #2 rst_n = 1'b1;
    src_f_valid = 1'b0; src_w_valid = 1'b0;
    step;
    v = '{5, 2, 1, 1, 0, 2, 16, 1, 0, 0};
    run_job(v);

    // A busy controller must ignore new descriptors
    job_shift = 10'd1; job_f_length = 10'd1; job_f_wbn = 5'd1; job_w_wbn = 5'd1;
    job_valid = 1'b1;
    step;
    job_shift = 10'd3; job_f_length = 10'd7;
    chk("busy_job_ready", job_ready, 0);
    step;
    chk("busy_ignores_job", cfg_f_length, 1);
    job_valid = 1'b0;
    src_f_valid = 1'b1; src_w_valid = 1'b1;
    k = 0;
    while (busy && k < 100) begin
      mon_out_valid = 1'b1; mon_out_last = 1'b1;
      step;
      k++;
    end
    mon_out_valid = 1'b0; mon_out_last = 1'b0;
    src_f_valid = 1'b0; src_w_valid = 1'b0;
    chk("busy_job_completes", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
